// File: rtl/plab5_mcore_mem_req_cmsg_pack_arb_if.sv
// Request/response bundle for the multi-port memory-request control-message packer.
// Requesters drive the master side; the packer implements the slave side.
interface plab5_mcore_mem_req_cmsg_pack_arb_if #(
  parameter int p_num_ports    = 4,
  parameter int p_opaque_nbits = 8,
  parameter int p_addr_nbits   = 32,
  parameter int p_data_nbits   = 32,
  parameter int p_queue_depth  = 2
);

  localparam int type_nbits  = 3;
  localparam int len_nbits   = $clog2(p_data_nbits/8);
  localparam int msg_nbits   = type_nbits + p_opaque_nbits + p_addr_nbits + len_nbits;
  localparam int count_nbits = $clog2(p_queue_depth) + 1;

  logic [p_num_ports-1:0]                in_val;
  logic [p_num_ports-1:0]                in_rdy;
  logic [p_num_ports*type_nbits-1:0]     in_type;
  logic [p_num_ports*p_opaque_nbits-1:0] in_opaque;
  logic [p_num_ports*p_addr_nbits-1:0]   in_addr;
  logic [p_num_ports*len_nbits-1:0]      in_len;

  logic                   out_val;
  logic                   out_rdy;
  logic [msg_nbits-1:0]   out_msg;
  logic [count_nbits-1:0] out_count;

  modport master (
    output in_val, in_type, in_opaque, in_addr, in_len, out_rdy,
    input  in_rdy, out_val, out_msg, out_count
  );

  modport slave (
    input  in_val, in_type, in_opaque, in_addr, in_len, out_rdy,
    output in_rdy, out_val, out_msg, out_count
  );

endinterface

// File: rtl/plab5_mcore_mem_req_cmsg_pack_arb.sv
// Round-robin arbiter over N request ports, packing the winner into {type,opaque,addr,len}
// and queueing it in a FIFO. Optional macro PLAB5_MCORE_CMSG_SRC_TAG_EN tags opaque with the source port.
module plab5_mcore_mem_req_cmsg_pack_arb #(
  parameter int p_num_ports    = 4,
  parameter int p_opaque_nbits = 8,
  parameter int p_addr_nbits   = 32,
  parameter int p_data_nbits   = 32,
  parameter int p_queue_depth  = 2
) (
  input logic clk,
  input logic reset,
  plab5_mcore_mem_req_cmsg_pack_arb_if.slave bus
);

  localparam int type_nbits = 3;
  localparam int len_nbits  = $clog2(p_data_nbits/8);
  localparam int msg_nbits  = type_nbits + p_opaque_nbits + p_addr_nbits + len_nbits;
  localparam int ptr_nbits  = $clog2(p_num_ports);
  localparam int q_nbits    = $clog2(p_queue_depth);

  typedef logic [ptr_nbits:0] scan_t;

  logic [ptr_nbits-1:0]      prio_ptr;
  scan_t                     scan;
  logic [p_num_ports-1:0]    grant;
  logic [ptr_nbits-1:0]      grant_idx;
  logic                      any_val;

  logic [type_nbits-1:0]     sel_type;
  logic [p_opaque_nbits-1:0] sel_opaque;
  logic [p_addr_nbits-1:0]   sel_addr;
  logic [len_nbits-1:0]      sel_len;
  logic [p_opaque_nbits-1:0] pack_opaque;
  logic [msg_nbits-1:0]      enq_msg;

  logic [msg_nbits-1:0]      storage [p_queue_depth];
  logic [q_nbits-1:0]        head;
  logic [q_nbits-1:0]        tail;
  logic [q_nbits:0]          count;
  logic                      full;
  logic                      enq;
  logic                      deq;

  // Round-robin scan starting at the priority pointer; first valid port wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_val   = 1'b0;
    scan      = '0;
    for (int k = 0; k < p_num_ports; k++) begin
      scan = {1'b0, prio_ptr} + scan_t'(k);
      if (scan >= scan_t'(p_num_ports)) begin
        scan = scan - scan_t'(p_num_ports);
      end else begin
        scan = scan;
      end
      if (!any_val && bus.in_val[scan[ptr_nbits-1:0]]) begin
        any_val                     = 1'b1;
        grant_idx                   = scan[ptr_nbits-1:0];
        grant[scan[ptr_nbits-1:0]]  = 1'b1;
      end else begin
        any_val = any_val;
      end
    end
  end

  // Select the winning port's fields from the flattened input buses.
  always_comb begin
    sel_type   = '0;
    sel_opaque = '0;
    sel_addr   = '0;
    sel_len    = '0;
    for (int i = 0; i < p_num_ports; i++) begin
      if (grant[i]) begin
        sel_type   = bus.in_type[i*type_nbits +: type_nbits];
        sel_opaque = bus.in_opaque[i*p_opaque_nbits +: p_opaque_nbits];
        sel_addr   = bus.in_addr[i*p_addr_nbits +: p_addr_nbits];
        sel_len    = bus.in_len[i*len_nbits +: len_nbits];
      end else begin
        sel_type   = sel_type;
      end
    end
  end

  // Opaque passes through, or carries the source port index in its low bits.
  always_comb begin
    pack_opaque = sel_opaque;
`ifdef PLAB5_MCORE_CMSG_SRC_TAG_EN
    pack_opaque[ptr_nbits-1:0] = grant_idx;
`endif
  end

  assign enq_msg = {sel_type, pack_opaque, sel_addr, sel_len};

  assign full = (count == (q_nbits+1)'(p_queue_depth));
  assign enq  = any_val && !full && !reset;
  assign deq  = bus.out_val && bus.out_rdy;

  assign bus.in_rdy    = grant & {p_num_ports{!full && !reset}};
  assign bus.out_val   = (count != '0) && !reset;
  assign bus.out_msg   = storage[head];
  assign bus.out_count = count;

  // FIFO pointers, occupancy and arbitration priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      prio_ptr <= '0;
    end else begin
      if (enq) begin
        tail <= tail + q_nbits'(1);
        if (grant_idx == ptr_nbits'(p_num_ports-1)) begin
          prio_ptr <= '0;
        end else begin
          prio_ptr <= grant_idx + ptr_nbits'(1);
        end
      end else begin
        tail     <= tail;
        prio_ptr <= prio_ptr;
      end
      if (deq) begin
        head <= head + q_nbits'(1);
      end else begin
        head <= head;
      end
      case ({enq, deq})
        2'b10:   count <= count + (q_nbits+1)'(1);
        2'b01:   count <= count - (q_nbits+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Message storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (enq) begin
      storage[tail] <= enq_msg;
    end else begin
      storage[tail] <= storage[tail];
    end
  end

endmodule

// File: tb/tb_plab5_mcore_mem_req_cmsg_pack_arb.sv
// Directed self-checking bench for the multi-port control-message packer/arbiter.
module tb_plab5_mcore_mem_req_cmsg_pack_arb;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  plab5_mcore_mem_req_cmsg_pack_arb_if bus ();

  plab5_mcore_mem_req_cmsg_pack_arb dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    bus.in_val    = '0;
    bus.in_type   = '0;
    bus.in_opaque = '0;
    bus.in_addr   = '0;
    bus.in_len    = '0;
  endtask

  task automatic set_port(input int p, input logic [2:0] ty, input logic [7:0] op,
                          input logic [31:0] ad, input logic [1:0] ln);
    bus.in_type[p*3 +: 3]    = ty;
    bus.in_opaque[p*8 +: 8]  = op;
    bus.in_addr[p*32 +: 32]  = ad;
    bus.in_len[p*2 +: 2]     = ln;
  endtask

  task automatic apply_reset;
    reset       = 1'b1;
    bus.out_rdy = 1'b0;
    clear_inputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset       = 1'b1;
    bus.out_rdy = 1'b1;
    set_port(0, 3'd1, 8'h00, 32'h0, 2'd0);
    bus.in_val = 4'hF;
    #1;
    n_cmp++;
    if (bus.in_rdy !== 4'b0000) begin n_bad++; $display("FAIL reset_in_rdy: got %b want %b", bus.in_rdy, 4'b0000); end
    tick();
    n_cmp++;
    if (bus.out_val !== 1'b0) begin n_bad++; $display("FAIL reset_out_val: got %b want 0", bus.out_val); end
    n_cmp++;
    if (bus.out_count !== 2'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", bus.out_count); end
    tick();
    reset = 1'b0;
    clear_inputs();
    #1;
    n_cmp++;
    if (bus.out_val !== 1'b0 || bus.out_count !== 2'd0) begin
      n_bad++; $display("FAIL post_reset_empty: got val=%b cnt=%0d want val=0 cnt=0", bus.out_val, bus.out_count);
    end
  endtask

  task automatic test_single;
    logic [44:0] exp_msg;
`ifdef PLAB5_MCORE_CMSG_SRC_TAG_EN
    exp_msg = {3'd0, 8'h10, 32'h0000_1000, 2'd0};
`else
    exp_msg = {3'd0, 8'h12, 32'h0000_1000, 2'd0};
`endif
    apply_reset();
    bus.out_rdy = 1'b1;
    set_port(0, 3'd0, 8'h12, 32'h0000_1000, 2'd0);
    bus.in_val = 4'b0001;
    #1;
    n_cmp++;
    if (bus.in_rdy !== 4'b0001) begin n_bad++; $display("FAIL single_in_rdy: got %b want %b", bus.in_rdy, 4'b0001); end
    tick();
    bus.in_val = 4'b0000;
    #1;
    n_cmp++;
    if (bus.out_val !== 1'b1) begin n_bad++; $display("FAIL single_out_val: got %b want 1", bus.out_val); end
    n_cmp++;
    if (bus.out_msg !== exp_msg) begin n_bad++; $display("FAIL single_msg: got %h want %h", bus.out_msg, exp_msg); end
    n_cmp++;
    if (bus.out_count !== 2'd1) begin n_bad++; $display("FAIL single_count: got %0d want 1", bus.out_count); end
    tick();
    n_cmp++;
    if (bus.out_val !== 1'b0 || bus.out_count !== 2'd0) begin
      n_bad++; $display("FAIL single_drain: got val=%b cnt=%0d want val=0 cnt=0", bus.out_val, bus.out_count);
    end
  endtask

  task automatic test_round_robin;
    logic [3:0]  rdy_exp  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [31:0] addr_exp [5] = '{32'h000, 32'h100, 32'h200, 32'h300, 32'h000};
    apply_reset();
    bus.out_rdy = 1'b1;
    set_port(0, 3'd0, 8'h20, 32'h000, 2'd0);
    set_port(1, 3'd1, 8'h21, 32'h100, 2'd0);
    set_port(2, 3'd2, 8'h22, 32'h200, 2'd0);
    set_port(3, 3'd3, 8'h23, 32'h300, 2'd0);
    bus.in_val = 4'hF;
    for (int j = 0; j < 5; j++) begin
      #1;
      n_cmp++;
      if (bus.in_rdy !== rdy_exp[j]) begin n_bad++; $display("FAIL rr_grant[%0d]: got %b want %b", j, bus.in_rdy, rdy_exp[j]); end
      tick();
      n_cmp++;
      if (bus.out_msg[33:2] !== addr_exp[j]) begin n_bad++; $display("FAIL rr_addr[%0d]: got %h want %h", j, bus.out_msg[33:2], addr_exp[j]); end
      n_cmp++;
      if (bus.out_count !== 2'd1) begin n_bad++; $display("FAIL rr_count[%0d]: got %0d want 1", j, bus.out_count); end
    end
    bus.in_val = 4'b0000;
    tick();
  endtask

  task automatic test_backpressure;
    logic [44:0] msg1;
    logic [44:0] msg2;
    msg1 = {3'd2, 8'h31, 32'h0000_0100, 2'd1};
    msg2 = {3'd3, 8'h32, 32'h0000_0200, 2'd2};
    apply_reset();
    bus.out_rdy = 1'b0;
    set_port(1, 3'd2, 8'h31, 32'h0000_0100, 2'd1);
    set_port(2, 3'd3, 8'h32, 32'h0000_0200, 2'd2);
    bus.in_val = 4'b0110;
    #1;
    n_cmp++;
    if (bus.in_rdy !== 4'b0010) begin n_bad++; $display("FAIL bp_grant0: got %b want %b", bus.in_rdy, 4'b0010); end
    tick();
    bus.in_val = 4'b0100;
    #1;
    n_cmp++;
    if (bus.in_rdy !== 4'b0100) begin n_bad++; $display("FAIL bp_grant1: got %b want %b", bus.in_rdy, 4'b0100); end
    tick();
    bus.in_val = 4'b0110;
    #1;
    n_cmp++;
    if (bus.out_count !== 2'd2) begin n_bad++; $display("FAIL bp_full_count: got %0d want 2", bus.out_count); end
    n_cmp++;
    if (bus.in_rdy !== 4'b0000) begin n_bad++; $display("FAIL bp_full_rdy: got %b want %b", bus.in_rdy, 4'b0000); end
    bus.out_rdy = 1'b1;
    #1;
    n_cmp++;
    if (bus.in_rdy !== 4'b0000) begin n_bad++; $display("FAIL bp_no_passthru: got %b want %b", bus.in_rdy, 4'b0000); end
    n_cmp++;
    if (bus.out_msg !== msg1) begin n_bad++; $display("FAIL bp_first_out: got %h want %h", bus.out_msg, msg1); end
    tick();
    bus.in_val = 4'b0000;
    #1;
    n_cmp++;
    if (bus.out_msg !== msg2 || bus.out_count !== 2'd1) begin
      n_bad++; $display("FAIL bp_second_out: got %h cnt=%0d want %h cnt=1", bus.out_msg, bus.out_count, msg2);
    end
    tick();
    n_cmp++;
    if (bus.out_val !== 1'b0) begin n_bad++; $display("FAIL bp_drained: got %b want 0", bus.out_val); end
  endtask

  task automatic test_simul_enq_deq;
    logic [44:0] msg0;
    logic [44:0] msg3;
    msg0 = {3'd0, 8'h40, 32'h0000_0040, 2'd0};
    msg3 = {3'd1, 8'h5B, 32'hDEAD_BEEC, 2'd3};
    apply_reset();
    bus.out_rdy = 1'b0;
    set_port(0, 3'd0, 8'h40, 32'h0000_0040, 2'd0);
    bus.in_val = 4'b0001;
    tick();
    set_port(3, 3'd1, 8'h5B, 32'hDEAD_BEEC, 2'd3);
    bus.in_val  = 4'b1000;
    bus.out_rdy = 1'b1;
    #1;
    n_cmp++;
    if (bus.in_rdy !== 4'b1000) begin n_bad++; $display("FAIL simul_grant: got %b want %b", bus.in_rdy, 4'b1000); end
    n_cmp++;
    if (bus.out_msg !== msg0) begin n_bad++; $display("FAIL simul_head: got %h want %h", bus.out_msg, msg0); end
    tick();
    bus.in_val = 4'b0000;
    #1;
    n_cmp++;
    if (bus.out_count !== 2'd1) begin n_bad++; $display("FAIL simul_count: got %0d want 1", bus.out_count); end
    n_cmp++;
    if (bus.out_msg !== msg3) begin n_bad++; $display("FAIL simul_msg: got %h want %h", bus.out_msg, msg3); end
    n_cmp++;
    if (bus.out_msg[44:42] !== 3'd1) begin n_bad++; $display("FAIL simul_type: got %0d want 1", bus.out_msg[44:42]); end
    tick();
  endtask

  task automatic test_mid_reset;
    apply_reset();
    bus.out_rdy = 1'b0;
    set_port(0, 3'd4, 8'h70, 32'h0000_7000, 2'd0);
    set_port(1, 3'd5, 8'h71, 32'h0000_7100, 2'd1);
    set_port(3, 3'd6, 8'h73, 32'h0000_7300, 2'd3);
    bus.in_val = 4'b0001;
    tick();
    bus.in_val = 4'b0010;
    tick();
    bus.in_val = 4'b0000;
    #1;
    n_cmp++;
    if (bus.out_count !== 2'd2) begin n_bad++; $display("FAIL mrst_fill: got %0d want 2", bus.out_count); end
    reset      = 1'b1;
    bus.in_val = 4'b1001;
    #1;
    n_cmp++;
    if (bus.in_rdy !== 4'b0000) begin n_bad++; $display("FAIL mrst_rdy_in_reset: got %b want %b", bus.in_rdy, 4'b0000); end
    tick();
    reset = 1'b0;
    #1;
    n_cmp++;
    if (bus.out_val !== 1'b0 || bus.out_count !== 2'd0) begin
      n_bad++; $display("FAIL mrst_cleared: got val=%b cnt=%0d want val=0 cnt=0", bus.out_val, bus.out_count);
    end
    n_cmp++;
    if (bus.in_rdy !== 4'b0001) begin n_bad++; $display("FAIL mrst_first_grant: got %b want %b", bus.in_rdy, 4'b0001); end
    tick();
    bus.in_val = 4'b0000;
    #1;
    n_cmp++;
    if (bus.out_msg[33:2] !== 32'h0000_7000 || bus.out_count !== 2'd1) begin
      n_bad++; $display("FAIL mrst_first_msg: got addr=%h cnt=%0d want addr=00007000 cnt=1", bus.out_msg[33:2], bus.out_count);
    end
  endtask

  task automatic test_wrap;
    logic [2:0]  ty;
    logic [7:0]  op;
    logic [31:0] ad;
    logic [1:0]  ln;
    logic [44:0] exp_msg;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      ty = 3'(i + 1);
      op = 8'h02 + 8'(4 * i);
      ad = 32'h0000_A000 + 32'(i);
      ln = 2'(i);
      exp_msg = {ty, op, ad, ln};
      set_port(2, ty, op, ad, ln);
      bus.out_rdy = 1'b0;
      bus.in_val  = 4'b0100;
      #1;
      n_cmp++;
      if (bus.in_rdy !== 4'b0100) begin n_bad++; $display("FAIL wrap_grant[%0d]: got %b want %b", i, bus.in_rdy, 4'b0100); end
      tick();
      bus.in_val  = 4'b0000;
      bus.out_rdy = 1'b1;
      #1;
      n_cmp++;
      if (bus.out_msg !== exp_msg) begin n_bad++; $display("FAIL wrap_msg[%0d]: got %h want %h", i, bus.out_msg, exp_msg); end
      tick();
      n_cmp++;
      if (bus.out_count !== 2'd0) begin n_bad++; $display("FAIL wrap_drain[%0d]: got %0d want 0", i, bus.out_count); end
    end
  endtask

  initial begin
    clk         = 1'b0;
    reset       = 1'b1;
    n_cmp       = 0;
    n_bad       = 0;
    bus.out_rdy = 1'b0;
    clear_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_simul_enq_deq();
    test_mid_reset();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/plab5_mcore_mem_req_cmsg_pack_arb.md
Name: plab5_mcore_mem_req_cmsg_pack_arb

Overview:
- Multi-port successor to the single-channel memory-request control-message packer.
- Takes N independent val/rdy request-control streams (type, opaque, addr, len) from cores or caches and arbitrates among them round-robin.
- Packs the winning request into one control message {type, opaque, addr, len}, MSB to LSB, and buffers it in a parametrised FIFO.
- Presents the FIFO head on a single val/rdy output toward the memory-side network. All security labels are {L}.

Parameters:
- p_num_ports, 4: number of requesters N, from 2 to 8.
- p_opaque_nbits, 8: opaque field width o.
- p_addr_nbits, 32: address field width a.
- p_data_nbits, 32: data width d. The len field width is l = clog2(d/8).
- p_queue_depth, 2: output FIFO entries. Power of two, at least 2.
- Derived: t = 3 (type width); c = t+o+a+l, which is 45 with the defaults.

Ports:
- clk, input, 1: clock. All state updates on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- in_val, input, N: per-port request valid.
- in_rdy, output, N: per-port request ready.
- in_type, input, N*t: per-port type. Port i occupies bits [i*t +: t].
- in_opaque, input, N*o: per-port opaque field.
- in_addr, input, N*a: per-port address.
- in_len, input, N*l: per-port length.
- out_val, output, 1: packed message valid.
- out_rdy, input, 1: downstream ready.
- out_msg, output, c: packed message. msg[c-1:l+a+o]=type, [l+a+o-1:l+a]=opaque, [l+a-1:l]=addr, [l-1:0]=len.
- out_count, output, clog2(p_queue_depth)+1: FIFO occupancy.

Behaviour:
- Reset: clears the FIFO (head, tail and count all 0) and sets the priority pointer to 0. During and after reset out_val=0, out_count=0 and in_rdy=0. FIFO storage contents are don't-care.
- Arbitration is combinational over in_val. It scans ports starting at the pointer, wrapping modulo N; the first asserted in_val wins.
- in_rdy[i] = win[i] && !full && !reset. At most one in_rdy bit is high in any cycle. in_rdy may depend on in_val.
- Enqueue: fires when some in_val is high and the FIFO is not full. The winner's fields are packed and written at tail, tail advances modulo depth, and the pointer becomes (winner+1) mod N on the same edge.
- With no enqueue, the pointer holds.
- Losing ports are not acknowledged and must hold their request stable.
- Dequeue: fires when out_val && out_rdy. Head advances modulo depth.
- out_val = (count != 0). out_msg is the head entry, driven combinationally from storage.
- Latency: a request accepted at edge k is visible on out_msg after edge k, provided the FIFO was empty. There is no same-cycle bypass.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance.
- When full, in_rdy is all 0, even if out_rdy=1 in the same cycle (no pass-through on full).
- Pointer wrap: head and tail wrap from depth-1 to 0. The priority pointer wraps from N-1 to 0.
- A reset asserted mid-stream discards all queued messages on that edge. No handshake completes in the reset cycle.
- Field packing is a pure bit concatenation. No field is truncated or extended; input widths match exactly.

Optional Feature:
- Macro: PLAB5_MCORE_CMSG_SRC_TAG_EN.
- When defined: the low clog2(N) bits of the packed opaque field are replaced with the winning port index. The upper opaque bits pass through unchanged. Requires o ≥ clog2(N).
- When undefined: opaque passes through unmodified.
- All other behaviour is identical in both builds.

Test Plan:
1. Single request: reset, then port 0 sends type=0, opaque=0x12, addr=0x1000, len=0, with out_rdy=1. Required: in_rdy[0]=1 in that cycle, and the next cycle shows out_val=1 and out_msg=0x0_12_00001000_0. With the tag feature enabled, opaque becomes 0x10.
2. Round-robin: all 4 ports hold in_val=1 with out_rdy=1. Required grant order 0,1,2,3,0. Each port's addr is 0x100*i, and out_msg addrs appear in the same order.
3. Full/backpressure: out_rdy=0, depth 2, ports 1 and 2 valid. Required: two enqueues, then out_count=2 and in_rdy=0 for all ports. Raising out_rdy then drains port 1's message first.
4. Simultaneous enqueue and dequeue at count=1: port 3 sends type=1 (write) with addr=0xDEADBEEC while out_rdy=1. Required: count stays 1, and the next message out is port 3's with type=1.
5. Mid-stream reset: FIFO holds 2 messages and reset is asserted for one cycle. Required: out_val=0 and out_count=0 on the next cycle, and the first grant after reset goes to port 0.
6. Wrap-around: 5 single-request/single-drain cycles through a depth-2 FIFO. Required: all messages emerge in order with no corruption across the head and tail wrap.
